// File: rtl/ipsxe_floating_point_invsqrt_group3_round_v1_0_if.sv
`default_nettype none
// ============================================================================
// Module      : ipsxe_floating_point_invsqrt_group3_round_v1_0_if
// Description : group3 partial-sum inputs and rounded mantissa result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ipsxe_floating_point_invsqrt_group3_round_v1_0_if #(
    parameter int MAN_WIDTH = 52,
    parameter int LO_W      = 46,
    parameter int HI_W      = 10
);
    logic                 i_lo_valid;
    logic [LO_W-1:0]      i_group3_lo;
    logic                 i_hi_valid;
    logic [HI_W-1:0]      i_group3_hi;
    logic                 o_valid;
    logic [MAN_WIDTH-1:0] o_man;
    logic [1:0]           o_exp_inc;
    logic                 o_align_err;

    modport master (
        output i_lo_valid, i_group3_lo, i_hi_valid, i_group3_hi,
        input  o_valid, o_man, o_exp_inc, o_align_err
    );

    modport slave (
        input  i_lo_valid, i_group3_lo, i_hi_valid, i_group3_hi,
        output o_valid, o_man, o_exp_inc, o_align_err
    );
endinterface
`default_nettype wire

// File: rtl/ipsxe_floating_point_invsqrt_group3_round_v1_0.sv
`default_nettype none
// ============================================================================
// Module      : ipsxe_floating_point_invsqrt_group3_round_v1_0
// Description : Aligns group3 lo/hi partial sums, normalizes and rounds (RNE).
// Revision    : 1.0 - initial release
// ============================================================================
module ipsxe_floating_point_invsqrt_group3_round_v1_0 #(
    parameter int MAN_WIDTH = 52,
    parameter int LO_W      = 46,
    parameter int HI_W      = 10,
    parameter int HI_DLY    = 1
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    ipsxe_floating_point_invsqrt_group3_round_v1_0_if.slave bus
);
    localparam int C_W = MAN_WIDTH + 4;

    logic            w_lo_v_d;
    logic [LO_W-1:0] w_lo_d;

    // lo arrives HI_DLY cycles ahead of hi; delay it so both meet at stage A
    generate
        if (HI_DLY == 0) begin : g_no_dly
            assign w_lo_v_d = bus.i_lo_valid;
            assign w_lo_d   = bus.i_group3_lo;
        end else begin : g_dly
            logic [HI_DLY-1:0] r_v_sr;
            logic [LO_W-1:0]   r_d_sr [HI_DLY];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_v_sr <= '0;
                    for (int i = 0; i < HI_DLY; i++) begin
                        r_d_sr[i] <= '0;
                    end
                end else begin
                    r_v_sr[0] <= bus.i_lo_valid;
                    r_d_sr[0] <= bus.i_group3_lo;
                    for (int i = 1; i < HI_DLY; i++) begin
                        r_v_sr[i] <= r_v_sr[i-1];
                        r_d_sr[i] <= r_d_sr[i-1];
                    end
                end
            end

            assign w_lo_v_d = r_v_sr[HI_DLY-1];
            assign w_lo_d   = r_d_sr[HI_DLY-1];
        end
    endgenerate

    logic           w_pair;
    logic [C_W-1:0] r_s;
    logic           r_va;
    logic           r_align_err;

    assign w_pair = bus.i_hi_valid & w_lo_v_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s         <= '0;
            r_va        <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_va <= w_pair;
            if (w_pair) begin
                r_s <= {bus.i_group3_hi, w_lo_d};
            end
            if (bus.i_hi_valid != w_lo_v_d) begin
                r_align_err <= 1'b1;
            end
        end
    end

    logic                 w_norm;
    logic [MAN_WIDTH:0]   w_m;
    logic                 w_g;
    logic                 w_st;
    logic                 w_rup;
    logic [MAN_WIDTH+1:0] w_mr;

    // A set MSB means the sum reached [2,4): shift one more bit out
    assign w_norm = r_s[C_W-1];
    assign w_m    = w_norm ? r_s[C_W-1:3] : r_s[C_W-2:2];
    assign w_g    = w_norm ? r_s[2] : r_s[1];
    assign w_st   = w_norm ? (|r_s[1:0]) : r_s[0];
    assign w_rup  = w_g & (w_st | w_m[0]);
    assign w_mr   = {1'b0, w_m} + {{(MAN_WIDTH+1){1'b0}}, w_rup};

    logic                 r_valid;
    logic [MAN_WIDTH-1:0] r_man;
    logic [1:0]           r_exp_inc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_man     <= '0;
            r_exp_inc <= 2'd0;
        end else begin
            r_valid <= r_va;
            if (r_va) begin
                // rounding carried past the hidden bit: mantissa wraps to 1.0
                if (w_mr[MAN_WIDTH+1]) begin
                    r_man     <= '0;
                    r_exp_inc <= w_norm ? 2'd2 : 2'd1;
                end else begin
                    r_man     <= w_mr[MAN_WIDTH-1:0];
                    r_exp_inc <= w_norm ? 2'd1 : 2'd0;
                end
            end
        end
    end

    assign bus.o_valid     = r_valid;
    assign bus.o_man       = r_man;
    assign bus.o_exp_inc   = r_exp_inc;
    assign bus.o_align_err = r_align_err;
endmodule
`default_nettype wire
